// File: rtl/evatop_sysctl.sv
// ICE system-control glue: ID/version serial readout, OCD soft-break, debounced TCCONNECT,
// sequenced EMVDD discharge and inspection constants, all in the 60 MHz ICE clock domain.
module evatop_sysctl #(
  parameter logic [31:0] IDVER     = 32'h3100_0014,
  parameter int unsigned NDIS      = 2,
  parameter int unsigned DIS_CNT_W = 16,
  parameter int unsigned TCC_DEB   = 4
) (
  input  logic                 CLK60MHZ,
  input  logic                 RESET,
  input  logic                 CLK60MHZLOCK,
  input  logic                 IDRQ,
  output logic                 IDSO,
  output logic                 IDSOVLD,
  input  logic                 SOFTBRK,
  input  logic                 OCDMOD,
  output logic                 SBANDOCD,
  input  logic                 SEL_TCCONNECT_B,
  inout  wire                  FPGA_TCCONNECT_B,
  input  logic                 DISEN,
  input  logic [DIS_CNT_W-1:0] DISTIME,
  output wire  [NDIS-1:0]      DISEM,
  output logic                 DISDONE,
  input  logic                 PSEUDOON30,
  output logic                 ICEREG,
  output logic                 LVISEL
);

  localparam int unsigned CH_W = (NDIS > 1) ? $clog2(NDIS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NDIS - 1);
  localparam logic [7:0] DEB_LAST = 8'(TCC_DEB - 1);

  typedef enum logic [1:0] {StIdle, StDis, StGap, StDone} dis_state_e;

  logic lock_ff, lock_s, irst;

  // Lock synchroniser is cleared by RESET only so that it can bring irst out of reset.
  always_ff @(posedge CLK60MHZ) begin
    if (RESET) begin
      lock_ff <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_ff <= CLK60MHZLOCK;
      lock_s  <= lock_ff;
    end
  end

  assign irst = RESET | ~lock_s;

  logic        idrq_q;
  logic [31:0] id_sr;
  logic [4:0]  id_cnt;

  // The last bit cycle (cnt == 0) also accepts a new request, giving back-to-back transfers.
  always_ff @(posedge CLK60MHZ) begin
    if (irst) begin
      idrq_q  <= 1'b0;
      id_sr   <= '0;
      id_cnt  <= '0;
      IDSOVLD <= 1'b0;
    end else begin
      idrq_q <= IDRQ;
      if (IDRQ && !idrq_q && (!IDSOVLD || id_cnt == '0)) begin
        id_sr   <= IDVER;
        id_cnt  <= 5'd31;
        IDSOVLD <= 1'b1;
      end else if (IDSOVLD) begin
        id_sr  <= {id_sr[30:0], 1'b0};
        id_cnt <= id_cnt - 5'd1;
        if (id_cnt == '0) IDSOVLD <= 1'b0;
      end
    end
  end

  assign IDSO = id_sr[31];

  always_ff @(posedge CLK60MHZ) begin
    if (RESET) SBANDOCD <= 1'b0;
    else       SBANDOCD <= SOFTBRK & ~OCDMOD;
  end

  logic       sel_ff, sel_s, tcc;
  logic [7:0] deb_cnt;

  always_ff @(posedge CLK60MHZ) begin
    if (RESET) begin
      sel_ff  <= 1'b1;
      sel_s   <= 1'b1;
      tcc     <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sel_ff <= SEL_TCCONNECT_B;
      sel_s  <= sel_ff;
      if (sel_s != tcc) begin
        if (deb_cnt == DEB_LAST) begin
          tcc     <= sel_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 8'd1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign FPGA_TCCONNECT_B = tcc ? 1'bz : 1'b0;

  dis_state_e           state;
  logic                 disen_q;
  logic [CH_W-1:0]      ch;
  logic [DIS_CNT_W-1:0] hold_m1, cnt, time_m1;
  logic [NDIS-1:0]      dis_act;

  // A zero hold time is treated as one cycle.
  assign time_m1 = (DISTIME == '0) ? '0 : DISTIME - DIS_CNT_W'(1);

  always_ff @(posedge CLK60MHZ) begin
    if (irst) begin
      state   <= StIdle;
      disen_q <= 1'b0;
      ch      <= '0;
      hold_m1 <= '0;
      cnt     <= '0;
      dis_act <= '0;
      DISDONE <= 1'b0;
    end else begin
      disen_q <= DISEN;
      if (!DISEN) begin
        state   <= StIdle;
        dis_act <= '0;
        DISDONE <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (!disen_q) begin
              hold_m1 <= time_m1;
              cnt     <= time_m1;
              ch      <= '0;
              dis_act <= NDIS'(1);
              state   <= StDis;
            end
          end
          StDis: begin
            if (cnt == '0) begin
              dis_act <= '0;
              if (ch == LAST_CH) begin
                state   <= StDone;
                DISDONE <= 1'b1;
              end else begin
                state <= StGap;
              end
            end else begin
              cnt <= cnt - DIS_CNT_W'(1);
            end
          end
          StGap: begin
            ch      <= ch + CH_W'(1);
            cnt     <= hold_m1;
            dis_act <= NDIS'(1) << (ch + CH_W'(1));
            state   <= StDis;
          end
          StDone: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NDIS; i++) begin : g_disem
    assign DISEM[i] = dis_act[i] ? 1'b0 : 1'bz;
  end

  assign ICEREG = PSEUDOON30;
  assign LVISEL = 1'b0;

endmodule

// File: tb/tb_evatop_sysctl.sv
// Scoreboard bench for evatop_sysctl: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares; an empty queue means the block is expected to be quiescent.
module tb_evatop_sysctl;

  localparam logic [31:0] IDVER     = 32'h3100_0014;
  localparam int unsigned NDIS      = 2;
  localparam int unsigned DIS_CNT_W = 16;
  localparam int unsigned TCC_DEB   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 RESET, CLK60MHZLOCK, IDRQ, SOFTBRK, OCDMOD, SEL_TCCONNECT_B;
  logic                 DISEN, PSEUDOON30;
  logic [DIS_CNT_W-1:0] DISTIME;
  logic                 IDSO, IDSOVLD, SBANDOCD, DISDONE, ICEREG, LVISEL;
  tri1                  fpga_tcc;
  tri1  [NDIS-1:0]      disem;

  evatop_sysctl #(
    .IDVER    (IDVER),
    .NDIS     (NDIS),
    .DIS_CNT_W(DIS_CNT_W),
    .TCC_DEB  (TCC_DEB)
  ) dut (
    .CLK60MHZ        (clk),
    .RESET           (RESET),
    .CLK60MHZLOCK    (CLK60MHZLOCK),
    .IDRQ            (IDRQ),
    .IDSO            (IDSO),
    .IDSOVLD         (IDSOVLD),
    .SOFTBRK         (SOFTBRK),
    .OCDMOD          (OCDMOD),
    .SBANDOCD        (SBANDOCD),
    .SEL_TCCONNECT_B (SEL_TCCONNECT_B),
    .FPGA_TCCONNECT_B(fpga_tcc),
    .DISEN           (DISEN),
    .DISTIME         (DISTIME),
    .DISEM           (disem),
    .DISDONE         (DISDONE),
    .PSEUDOON30      (PSEUDOON30),
    .ICEREG          (ICEREG),
    .LVISEL          (LVISEL)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic sb_exp = 1'b0;
  logic tcc_m = 1'b1;
  logic sel_lvl = 1'b1;

  logic [1:0]    id_q[$];   // {valid, bit}
  logic [NDIS:0] dis_q[$];  // {done, disem}
  logic          tcc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Discharge output after the j-th edge following the sampled DISEN rise.
  function automatic logic [NDIS:0] dis_trace(input int tp, input int j);
    int period, c, r;
    period = tp + 1;
    if (j >= int'(NDIS) * period - 1) return {1'b1, {NDIS{1'b1}}};
    c = j / period;
    r = j % period;
    if (r < tp) return {1'b0, ~(NDIS'(1) << c)};
    return {1'b0, {NDIS{1'b1}}};
  endfunction

  always @(posedge clk) sb_exp <= RESET ? 1'b0 : (SOFTBRK & ~OCDMOD);

  always @(negedge clk) begin : monitor
    logic [1:0]    ide;
    logic [NDIS:0] de;
    if (mon_en) begin
      ide = 2'b00;
      if (id_q.size() > 0) ide = id_q.pop_front();
      check("idsovld", 32'(IDSOVLD), 32'(ide[1]));
      if (ide[1]) check("idso", 32'(IDSO), 32'(ide[0]));
      de = {1'b0, {NDIS{1'b1}}};
      if (dis_q.size() > 0) de = dis_q.pop_front();
      check("disem", 32'(disem), 32'(de[NDIS-1:0]));
      check("disdone", 32'(DISDONE), 32'(de[NDIS]));
      if (tcc_q.size() > 0) tcc_m = tcc_q.pop_front();
      check("tcconnect", 32'(fpga_tcc), 32'(tcc_m));
      check("sbandocd", 32'(SBANDOCD), 32'(sb_exp));
      check("icereg", 32'(ICEREG), 32'(PSEUDOON30));
      check("lvisel", 32'(LVISEL), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    SOFTBRK    = 1'($urandom);
    OCDMOD     = 1'($urandom);
    PSEUDOON30 = 1'($urandom);
    #1;
    check("icereg_comb", 32'(ICEREG), 32'(PSEUDOON30));
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 300; i++) begin
      if (id_q.size() == 0 && dis_q.size() == 0 && tcc_q.size() == 0) return;
      step();
    end
    n_chk++;
    $display("FAIL timeout: queues id=%0d dis=%0d tcc=%0d required 0", id_q.size(),
             dis_q.size(), tcc_q.size());
  endtask

  task automatic id_req();
    logic [31:0] w;
    w = IDVER;
    if (id_q.size() > 0 && id_q.size() <= 5) wait_quiet();
    // A request during an active transfer is dropped, so nothing is expected for it.
    if (id_q.size() == 0) begin
      id_q.push_back(2'b00);
      for (int n = 31; n >= 0; n--) id_q.push_back({1'b1, w[n]});
    end
    IDRQ = 1'b1;
    step();
    IDRQ = 1'b0;
  endtask

  // Raise DISEN for `hold` edges, then end the sequence by DISEN fall or by lock loss.
  task automatic dis_run(input int t, input int hold, input bit by_lock);
    int tp;
    tp = (t == 0) ? 1 : t;
    DISTIME = DIS_CNT_W'(t);
    DISEN = 1'b1;
    dis_q.push_back({1'b0, {NDIS{1'b1}}});
    for (int j = 0; j < hold + 4; j++) dis_q.push_back(dis_trace(tp, j));
    step();
    DISTIME = DIS_CNT_W'($urandom_range(9));
    repeat (hold - 1) step();
    if (!by_lock) begin
      DISEN = 1'b0;
      while (dis_q.size() > 1) void'(dis_q.pop_back());
      step();
      step();
    end else begin
      // Lock loss takes three edges to reach the reset state.
      CLK60MHZLOCK = 1'b0;
      while (dis_q.size() > 3) void'(dis_q.pop_back());
      while (id_q.size() > 3) void'(id_q.pop_back());
      repeat (6) step();
      DISEN = 1'b0;
      step();
      CLK60MHZLOCK = 1'b1;
      repeat (4) step();
    end
  endtask

  task automatic tcc_glitch(input int g);
    SEL_TCCONNECT_B = ~sel_lvl;
    repeat (g) step();
    SEL_TCCONNECT_B = sel_lvl;
    repeat (8) step();
  endtask

  task automatic tcc_change();
    logic old;
    wait_quiet();
    old = tcc_m;
    sel_lvl = ~sel_lvl;
    SEL_TCCONNECT_B = sel_lvl;
    repeat (2 + TCC_DEB) tcc_q.push_back(old);
    tcc_q.push_back(~old);
    repeat (10) step();
  endtask

  initial begin
    int op, t, tp;
    RESET = 1'b1;
    CLK60MHZLOCK = 1'b1;
    IDRQ = 1'b0;
    SOFTBRK = 1'b0;
    OCDMOD = 1'b0;
    SEL_TCCONNECT_B = 1'b1;
    DISEN = 1'b0;
    DISTIME = '0;
    PSEUDOON30 = 1'b0;
    step();
    mon_en = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    repeat (4) step();

    id_req();
    repeat (10) step();
    id_req();
    wait_quiet();
    repeat (3) step();

    dis_run(3, 10, 1'b0);
    dis_run(3, 6, 1'b0);
    dis_run(3, 10, 1'b0);
    dis_run(0, 6, 1'b0);

    tcc_glitch(3);
    tcc_glitch(1);
    tcc_change();
    tcc_glitch(3);
    tcc_change();
    tcc_change();

    id_req();
    repeat (5) step();
    dis_run(2, 4, 1'b1);
    wait_quiet();
    tcc_change();

    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(3);
      t = $urandom_range(4);
      tp = (t == 0) ? 1 : t;
      case (op)
        0: begin
          id_req();
          repeat ($urandom_range(40)) step();
        end
        1: dis_run(t, 1 + $urandom_range(int'(NDIS) * (tp + 1) + 2), 1'b0);
        2: begin
          if ($urandom_range(1) == 0) tcc_glitch(1 + $urandom_range(TCC_DEB - 2));
          else tcc_change();
        end
        default: dis_run(t, 1 + $urandom_range(int'(NDIS) * (tp + 1)), 1'b1);
      endcase
    end

    wait_quiet();
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
